// File: rtl/dino_motion_ctrl.sv
// rtl/dino_motion_ctrl.sv - T-rex jump physics, leg animation and dead pose per video frame
module dino_motion_ctrl #(
    parameter int DINO_X     = 50,
    parameter int GROUND_Y   = 300,
    parameter int DUCK_Y_OFS = 34,
    parameter int JUMP_V     = 20,
    parameter int GRAVITY    = 1,
    parameter int FAST_FALL  = 3,
    parameter int ANIM_DIV   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       jump,
    input  logic       duck,
    input  logic       collide,
    input  logic       start,
    output logic [9:0] DinoX,
    output logic [8:0] DinoY,
    output logic [3:0] AnimateSel,
    output logic       is_dead,
    output logic       airborne
);
    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(ANIM_DIV - 1);
    localparam logic [8:0]         Y_GND    = 9'(GROUND_Y);
    localparam logic [8:0]         Y_DUCK   = 9'(GROUND_Y + DUCK_Y_OFS);
    localparam logic signed [9:0]  GRAV10   = 10'(GRAVITY);
    localparam logic signed [9:0]  FAST10   = 10'(FAST_FALL);
    localparam logic signed [9:0]  V_MIN    = -10'sd64;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DUCK, S_JUMP, S_DEAD} state_t;

    state_t             state, state_nxt;
    logic [8:0]         h, h_nxt;
    logic signed [7:0]  v, v_nxt;
    logic [CW-1:0]      anim_cnt, anim_cnt_nxt;
    logic               phase, phase_nxt;
    logic signed [9:0]  h_sum, v_dec;
    logic [CW-1:0]      cnt_step;
    logic               phase_step;

    // Height and velocity are widened to signed 10 bits so landing is a plain sign test
    assign h_sum = $signed({1'b0, h}) + $signed({{2{v[7]}}, v});
    assign v_dec = $signed({{2{v[7]}}, v}) - GRAV10 - (duck ? FAST10 : 10'sd0);

    assign cnt_step   = (anim_cnt == CNT_LAST) ? '0 : anim_cnt + 1'b1;
    assign phase_step = (anim_cnt == CNT_LAST) ? ~phase : phase;

    always_comb begin
        state_nxt    = state;
        h_nxt        = h;
        v_nxt        = v;
        anim_cnt_nxt = anim_cnt;
        phase_nxt    = phase;
        case (state)
            S_IDLE, S_DEAD: begin
                if (start) begin
                    state_nxt    = S_RUN;
                    h_nxt        = '0;
                    v_nxt        = '0;
                    anim_cnt_nxt = '0;
                    phase_nxt    = 1'b0;
                end
            end
            S_RUN, S_DUCK: begin
                if (collide) begin
                    state_nxt = S_DEAD;
                end else if (frame_tick) begin
                    anim_cnt_nxt = cnt_step;
                    phase_nxt    = phase_step;
                    if (jump) begin
                        state_nxt = S_JUMP;
                        h_nxt     = '0;
                        v_nxt     = 8'(JUMP_V);
                    end else if (duck) begin
                        state_nxt = S_DUCK;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_JUMP: begin
                if (collide) begin
                    state_nxt = S_DEAD;
                end else if (frame_tick) begin
                    if (h_sum <= 10'sd0) begin
                        state_nxt = duck ? S_DUCK : S_RUN;
                        h_nxt     = '0;
                        v_nxt     = '0;
                    end else begin
                        h_nxt = h_sum[8:0];
                        v_nxt = (v_dec < V_MIN) ? V_MIN[7:0] : v_dec[7:0];
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they land one edge after sampling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            h          <= '0;
            v          <= '0;
            anim_cnt   <= '0;
            phase      <= 1'b0;
            DinoX      <= 10'(DINO_X);
            DinoY      <= Y_GND;
            AnimateSel <= 4'b0000;
            is_dead    <= 1'b0;
            airborne   <= 1'b0;
        end else begin
            state    <= state_nxt;
            h        <= h_nxt;
            v        <= v_nxt;
            anim_cnt <= anim_cnt_nxt;
            phase    <= phase_nxt;
            DinoX    <= 10'(DINO_X);
            is_dead  <= (state_nxt == S_DEAD);
            airborne <= (state_nxt == S_JUMP);
            case (state_nxt)
                S_DEAD:  DinoY <= DinoY;
                S_DUCK:  DinoY <= Y_DUCK;
                default: DinoY <= Y_GND - h_nxt;
            endcase
            case (state_nxt)
                S_DEAD:  AnimateSel <= 4'b0001;
                S_RUN:   AnimateSel <= phase_nxt ? 4'b0111 : 4'b0011;
                S_DUCK:  AnimateSel <= phase_nxt ? 4'b1011 : 4'b0010;
                default: AnimateSel <= 4'b0000;
            endcase
        end
    end
endmodule

// File: tb/tb_dino_motion_ctrl.sv
// tb/tb_dino_motion_ctrl.sv - vector table plus jump/death/reset sequences for dino_motion_ctrl
module tb_dino_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0, jump = 1'b0, duck = 1'b0, collide = 1'b0, start = 1'b0;
    logic [9:0] DinoX;
    logic [8:0] DinoY;
    logic [3:0] AnimateSel;
    logic       is_dead, airborne;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       t, j, d, c, s;
        logic [3:0] sel;
        logic [8:0] y;
        logic       dead, air;
    } vec_t;
    vec_t tbl[$];

    dino_motion_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .jump(jump), .duck(duck),
        .collide(collide), .start(start), .DinoX(DinoX), .DinoY(DinoY),
        .AnimateSel(AnimateSel), .is_dead(is_dead), .airborne(airborne)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic t, j, d, c, s, input logic [3:0] sel,
                                input logic [8:0] y, input logic dead, air, input int rep);
        for (int k = 0; k < rep; k++) begin
            vec_t e;
            e.t = t; e.j = j; e.d = d; e.c = c; e.s = s;
            e.sel = sel; e.y = y; e.dead = dead; e.air = air;
            tbl.push_back(e);
        end
    endfunction

    // One-cycle input pulse; returns at the negedge after the sampling edge
    task automatic step(input logic t, j, d, c, s);
        @(negedge clk);
        frame_tick = t; jump = j; duck = d; collide = c; start = s;
        @(negedge clk);
        frame_tick = 0; jump = 0; duck = 0; collide = 0; start = 0;
    endtask

    task automatic chk(input string nm, input logic [3:0] es, input logic [8:0] ey,
                       input logic ed, input logic ea);
        n_chk++;
        if (AnimateSel === es && DinoY === ey && is_dead === ed && airborne === ea)
            n_pass++;
        else
            $display("FAIL %s: sel=%b y=%0d dead=%b air=%b, expected sel=%b y=%0d dead=%b air=%b",
                     nm, AnimateSel, DinoY, is_dead, airborne, es, ey, ed, ea);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Run/duck animation from reset
        add(0,0,0,1,0, 4'b0000, 9'd300, 0, 0, 1);   // collide ignored in IDLE
        add(0,0,0,0,1, 4'b0011, 9'd300, 0, 0, 1);   // start
        add(1,0,0,0,0, 4'b0011, 9'd300, 0, 0, 5);   // ticks 1-5
        add(1,0,0,0,0, 4'b0111, 9'd300, 0, 0, 6);   // ticks 6-11
        add(1,0,0,0,0, 4'b0011, 9'd300, 0, 0, 1);   // tick 12
        add(1,0,1,0,0, 4'b0010, 9'd334, 0, 0, 5);   // duck ticks 13-17
        add(1,0,1,0,0, 4'b1011, 9'd334, 0, 0, 6);   // 18-23
        add(1,0,1,0,0, 4'b0010, 9'd334, 0, 0, 1);   // 24
        add(1,0,0,0,0, 4'b0011, 9'd300, 0, 0, 1);   // release
        add(0,1,0,0,0, 4'b0011, 9'd300, 0, 0, 1);   // jump without tick: nothing
        add(1,1,0,0,0, 4'b0000, 9'd300, 0, 1, 1);   // jump tick

        rst = 1'b0;
        #12;
        n_chk++;
        if (DinoX === 10'd50) n_pass++;
        else $display("FAIL reset_dinox: got %0d, expected 50", DinoX);
        chk("reset_state", 4'b0000, 9'd300, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].t, tbl[i].j, tbl[i].d, tbl[i].c, tbl[i].s);
            chk($sformatf("vec%0d", i), tbl[i].sel, tbl[i].y, tbl[i].dead, tbl[i].air);
        end

        // Full jump arc: peak 90 at n=20/21, landing at n=41
        for (int n = 1; n <= 41; n++) begin
            step(1, 0, 0, 0, 0);
            if (n == 1)  chk("jump_n1",  4'b0000, 9'd280, 0, 1);
            if (n == 20) chk("jump_n20", 4'b0000, 9'd90,  0, 1);
            if (n == 21) begin
                chk("jump_n21", 4'b0000, 9'd90, 0, 1);
                step(0, 0, 0, 0, 0);
                chk("jump_no_tick", 4'b0000, 9'd90, 0, 1);
            end
            if (n == 40) chk("jump_n40", 4'b0000, 9'd280, 0, 1);
            if (n == 41) chk("jump_land", 4'b0011, 9'd300, 0, 0);
        end

        // Collide mid-jump, freeze, restart clears animation
        do_reset();
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        for (int n = 1; n <= 9; n++) step(1, 0, 0, 0, 0);
        chk("pre_collide", 4'b0000, 9'd156, 0, 1);
        step(0, 0, 0, 1, 0);
        chk("collide_dead", 4'b0001, 9'd156, 1, 0);
        step(1, 1, 0, 1, 0);
        chk("dead_frozen", 4'b0001, 9'd156, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("restart", 4'b0011, 9'd300, 0, 0);
        for (int n = 1; n <= 5; n++) step(1, 0, 0, 0, 0);
        chk("restart_cnt5", 4'b0011, 9'd300, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("restart_cnt6", 4'b0111, 9'd300, 0, 0);

        // Collide and jump on the same tick
        step(1, 1, 0, 1, 0);
        chk("collide_wins", 4'b0001, 9'd300, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("restart2", 4'b0011, 9'd300, 0, 0);

        // Fast fall: duck from n=22 lands into DUCK at n=32
        do_reset();
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        for (int n = 1; n <= 32; n++) begin
            step(1, 0, n >= 22, 0, 0);
            if (n == 22) chk("ff_n22", 4'b0000, 9'd91,  0, 1);
            if (n == 31) chk("ff_n31", 4'b0000, 9'd280, 0, 1);
            if (n == 32) chk("ff_land", 4'b0010, 9'd334, 0, 0);
        end

        // Asynchronous reset mid-jump
        step(1, 1, 0, 0, 0);
        for (int n = 1; n <= 5; n++) step(1, 0, 0, 0, 0);
        chk("pre_async", 4'b0000, 9'd210, 0, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 9'd300, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 0, 0, 0);
        chk("idle_after_reset", 4'b0000, 9'd300, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
